// File: rtl/mem_dump_pkg.sv
// Shared types and constants for the memory dump reader.
// Optional feature: MEM_DUMP_CHECKSUM_EN adds the trailing checksum word and its state.
package mem_dump_pkg;

   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned ADDR_W_DEF     = 12;
   localparam int unsigned CNT_W_DEF      = 11;

   typedef enum logic [2:0] {
      StIdle,
      StRead,
      StSend,
`ifdef MEM_DUMP_CHECKSUM_EN
      StCsum,
`endif
      StDone
   } state_e;

endpackage

// File: rtl/mem_byte_packer.sv
// Little-endian byte packer: each captured byte enters at the top and shifts down,
// so after BYTES_PER_WORD captures the first byte sits in bits [7:0].
module mem_byte_packer
   import mem_dump_pkg::*;
(
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          cap_i,
   input  logic [7:0]                    byte_i,
   output logic [8*BYTES_PER_WORD-1:0]   word_o
);

   localparam int unsigned WordW = 8 * BYTES_PER_WORD;

   logic [WordW-1:0] word_q, word_d;

   // Shift the new byte in from the top when a read result is valid.
   always_comb begin
      word_d = word_q;
      if (cap_i) begin
         word_d = {byte_i, word_q[WordW-1:8]};
      end
   end

   // Pack register with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         word_q <= '0;
      end else begin
         word_q <= word_d;
      end
   end

   assign word_o = word_q;

endmodule

// File: rtl/mem_dump_reader.sv
// Streams word_count 32-bit words read bytewise from a data memory starting at base_addr.
// Optional feature: define MEM_DUMP_CHECKSUM_EN to append a wrapping-sum checksum word.
module mem_dump_reader
   import mem_dump_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   // READ spans BYTES_PER_WORD issue cycles plus one cycle to capture the final byte.
   localparam logic [2:0] RdLast = 3'(BYTES_PER_WORD);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]  left_q, left_d;
   logic [2:0]        rd_cnt_q, rd_cnt_d;
   logic              cap_q;
   logic [31:0]       packed_word;
   logic              last_word;
`ifdef MEM_DUMP_CHECKSUM_EN
   logic [31:0]       csum_q, csum_d;
`endif

   mem_byte_packer u_packer (
      .clk_i  (clk),
      .rst_ni (reset),
      .cap_i  (cap_q),
      .byte_i (mem_rdata),
      .word_o (packed_word)
   );

   assign last_word = (left_q == CNT_W'(1));

   // Next-state logic and registered-state-decoded outputs.
   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      left_d    = left_q;
      rd_cnt_d  = rd_cnt_q;
`ifdef MEM_DUMP_CHECKSUM_EN
      csum_d    = csum_q;
`endif
      mem_rd_en = 1'b0;
      mem_addr  = '0;
      out_valid = 1'b0;
      out_data  = '0;
      out_addr  = '0;
      out_last  = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state_q)
         StIdle: begin
            busy = 1'b0;
            if (start) begin
               base_d   = base_addr;
               left_d   = word_count;
               rd_cnt_d = '0;
`ifdef MEM_DUMP_CHECKSUM_EN
               csum_d   = '0;
`endif
               state_d  = (word_count == '0) ? StDone : StRead;
            end
         end
         StRead: begin
            if (rd_cnt_q != RdLast) begin
               mem_rd_en = 1'b1;
               mem_addr  = base_q + ADDR_W'(rd_cnt_q);
            end
            rd_cnt_d = rd_cnt_q + 3'd1;
            if (rd_cnt_q == RdLast) begin
               state_d = StSend;
            end
         end
         StSend: begin
            out_valid = 1'b1;
            out_data  = packed_word;
            out_addr  = base_q;
`ifndef MEM_DUMP_CHECKSUM_EN
            out_last  = last_word;
`endif
            if (out_ready) begin
               base_d   = base_q + ADDR_W'(BYTES_PER_WORD);
               left_d   = left_q - CNT_W'(1);
               rd_cnt_d = '0;
`ifdef MEM_DUMP_CHECKSUM_EN
               csum_d   = csum_q + packed_word;
               state_d  = last_word ? StCsum : StRead;
`else
               state_d  = last_word ? StDone : StRead;
`endif
            end
         end
`ifdef MEM_DUMP_CHECKSUM_EN
         StCsum: begin
            // base_q has already advanced past the last data word.
            out_valid = 1'b1;
            out_data  = csum_q;
            out_addr  = base_q;
            out_last  = 1'b1;
            if (out_ready) begin
               state_d = StDone;
            end
         end
`endif
         StDone: begin
            busy    = 1'b0;
            done    = 1'b1;
            state_d = StIdle;
         end
         default: begin
            busy    = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   // State and counter registers; reset aborts any dump in progress.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= StIdle;
         base_q   <= '0;
         left_q   <= '0;
         rd_cnt_q <= '0;
         cap_q    <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
         csum_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         left_q   <= left_d;
         rd_cnt_q <= rd_cnt_d;
         cap_q    <= mem_rd_en;
`ifdef MEM_DUMP_CHECKSUM_EN
         csum_q   <= csum_d;
`endif
      end
   end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed self-checking bench for mem_dump_reader (honours MEM_DUMP_CHECKSUM_EN).
module tb_mem_dump_reader;

   localparam int AW = 12;
   localparam int CW = 11;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [CW-1:0] word_count;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_rdata;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_data;
   logic [AW-1:0] out_addr;
   logic          out_last;
   logic          busy;
   logic          done;

   int n_checks = 0;
   int n_fail   = 0;
   int rd_total = 0;
   int valid_total = 0;

   logic [7:0] mem [4096];

`ifdef MEM_DUMP_CHECKSUM_EN
   localparam logic LAST_ON_DATA = 1'b0;
`else
   localparam logic LAST_ON_DATA = 1'b1;
`endif

   always #5 clk = ~clk;

   // Byte memory with one-cycle read latency.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= mem[mem_addr];
   end

   // Running counts of read strobes and valid cycles.
   always @(posedge clk) begin
      if (mem_rd_en) rd_total <= rd_total + 1;
      if (out_valid) valid_total <= valid_total + 1;
   end

   mem_dump_reader #(.ADDR_W(AW), .CNT_W(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .mem_rd_en  (mem_rd_en),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_addr   (out_addr),
      .out_last   (out_last),
      .busy       (busy),
      .done       (done)
   );

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(output int cyc, output bit ok);
      cyc = 0;
      ok  = 1'b0;
      while (cyc < 40) begin
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
         step(1);
         cyc++;
      end
   endtask

   task automatic kick(input logic [AW-1:0] b, input logic [CW-1:0] c);
      base_addr  = b;
      word_count = c;
      start      = 1'b1;
      step(1);
      start      = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b0; start = 1'b0; out_ready = 1'b0; base_addr = '0; word_count = '0;
      step(2);
      n_checks++;
      if ({mem_rd_en, out_valid, out_last, busy, done} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 00000",
                  {mem_rd_en, out_valid, out_last, busy, done});
      end
      n_checks++;
      if (mem_addr !== 12'h000) begin
         n_fail++; $display("FAIL reset_mem_addr: got %h expected 000", mem_addr);
      end
      n_checks++;
      if (out_data !== 32'h0) begin
         n_fail++; $display("FAIL reset_out_data: got %h expected 00000000", out_data);
      end
      n_checks++;
      if (out_addr !== 12'h000) begin
         n_fail++; $display("FAIL reset_out_addr: got %h expected 000", out_addr);
      end
      reset = 1'b1;
      step(1);
   endtask

   task automatic test_basic;
      int cyc; bit ok; int r0;
      r0 = rd_total;
      out_ready = 1'b1;
      kick(12'h000, 11'd2);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL basic_busy: got %b expected 1", busy);
      end
      wait_valid(cyc, ok);
      n_checks++;
      if (!ok || cyc + 1 != 6) begin
         n_fail++; $display("FAIL basic_latency: got %0d (ok=%0b) expected 6", cyc + 1, ok);
      end
      n_checks++;
      if (out_data !== 32'h04030201 || out_addr !== 12'h000 || out_last !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_word0: got %h @%h last=%b expected 04030201 @000 last=0",
                  out_data, out_addr, out_last);
      end
      step(1);
      wait_valid(cyc, ok);
      n_checks++;
      if (!ok || cyc != 5) begin
         n_fail++; $display("FAIL basic_gap: got %0d (ok=%0b) expected 5", cyc, ok);
      end
      n_checks++;
      if (out_data !== 32'h08070605 || out_addr !== 12'h004 || out_last !== LAST_ON_DATA) begin
         n_fail++;
         $display("FAIL basic_word1: got %h @%h last=%b expected 08070605 @004 last=%b",
                  out_data, out_addr, out_last, LAST_ON_DATA);
      end
      step(1);
`ifdef MEM_DUMP_CHECKSUM_EN
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h0C0A0806 || out_addr !== 12'h008
          || out_last !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_csum: got v=%b %h @%h last=%b expected v=1 0c0a0806 @008 last=1",
                  out_valid, out_data, out_addr, out_last);
      end
      step(1);
`endif
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL basic_done: got done=%b busy=%b expected 1 0", done, busy);
      end
      step(1);
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done);
      end
      n_checks++;
      if (rd_total - r0 != 8) begin
         n_fail++; $display("FAIL basic_reads: got %0d expected 8", rd_total - r0);
      end
   endtask

   task automatic test_backpressure;
      int cyc; bit ok; int r0; bit seen;
      r0 = rd_total;
      out_ready = 1'b0;
      kick(12'h000, 11'd2);
      wait_valid(cyc, ok);
      for (int i = 0; i < 10; i++) begin
         step(1);
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== 32'h04030201 || out_addr !== 12'h000) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got v=%b %h @%h expected v=1 04030201 @000",
                     i, out_valid, out_data, out_addr);
         end
      end
      n_checks++;
      if (rd_total - r0 != 4) begin
         n_fail++; $display("FAIL stall_reads: got %0d expected 4", rd_total - r0);
      end
      out_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step(1);
         if (done) seen = 1'b1;
      end
      n_checks++;
      if (!seen) begin
         n_fail++; $display("FAIL stall_drain: got no done expected done");
      end
      step(1);
   endtask

   task automatic test_zero;
      int r0; int v0;
      r0 = rd_total; v0 = valid_total;
      out_ready = 1'b1;
      kick(12'h000, 11'd0);
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL zero_done: got done=%b busy=%b expected 1 0", done, busy);
      end
      step(1);
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++; $display("FAIL zero_done_pulse: got %b expected 0", done);
      end
      step(3);
      n_checks++;
      if (rd_total != r0 || valid_total != v0) begin
         n_fail++;
         $display("FAIL zero_quiet: got reads=%0d valids=%0d expected 0 0",
                  rd_total - r0, valid_total - v0);
      end
   endtask

   task automatic test_reset_abort;
      int cyc; bit ok; int r0; int v0;
      out_ready = 1'b0;
      kick(12'h000, 11'd3);
      step(2);
      kick(12'h100, 11'd1);
      wait_valid(cyc, ok);
      n_checks++;
      if (!ok || out_data !== 32'h04030201 || out_addr !== 12'h000) begin
         n_fail++;
         $display("FAIL abort_word0: got %h @%h expected 04030201 @000", out_data, out_addr);
      end
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
      wait_valid(cyc, ok);
      n_checks++;
      if (!ok || out_addr !== 12'h004 || out_data !== 32'h08070605) begin
         n_fail++;
         $display("FAIL abort_word1: got %h @%h expected 08070605 @004", out_data, out_addr);
      end
      reset = 1'b0;
      step(1);
      n_checks++;
      if ({mem_rd_en, out_valid, out_last, busy, done} !== 5'b0 || mem_addr !== 12'h000
          || out_data !== 32'h0 || out_addr !== 12'h000) begin
         n_fail++;
         $display("FAIL abort_outputs: got ctl=%b ma=%h d=%h oa=%h expected all zero",
                  {mem_rd_en, out_valid, out_last, busy, done}, mem_addr, out_data, out_addr);
      end
      reset = 1'b1;
      out_ready = 1'b1;
      r0 = rd_total; v0 = valid_total;
      step(10);
      n_checks++;
      if (rd_total != r0 || valid_total != v0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_quiet: got reads=%0d valids=%0d busy=%b expected 0 0 0",
                  rd_total - r0, valid_total - v0, busy);
      end
   endtask

   task automatic test_wrap;
      int cyc; bit ok;
      mem[12'hFFE] = 8'hAA; mem[12'hFFF] = 8'hBB;
      mem[12'h000] = 8'hCC; mem[12'h001] = 8'hDD;
      out_ready = 1'b1;
      kick(12'hFFE, 11'd1);
      wait_valid(cyc, ok);
      n_checks++;
      if (!ok || out_data !== 32'hDDCCBBAA || out_addr !== 12'hFFE
          || out_last !== LAST_ON_DATA) begin
         n_fail++;
         $display("FAIL wrap_word: got %h @%h last=%b expected ddccbbaa @ffe last=%b",
                  out_data, out_addr, out_last, LAST_ON_DATA);
      end
      step(1);
`ifdef MEM_DUMP_CHECKSUM_EN
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hDDCCBBAA || out_addr !== 12'h002
          || out_last !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_csum: got v=%b %h @%h last=%b expected v=1 ddccbbaa @002 last=1",
                  out_valid, out_data, out_addr, out_last);
      end
      step(1);
`endif
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++; $display("FAIL wrap_done: got %b expected 1", done);
      end
      step(1);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);
      test_reset();
      test_basic();
      test_backpressure();
      test_zero();
      test_reset_abort();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_dump_reader.md
MEM_DUMP_READER -- requirements
Module: mem_dump_reader

Interface
REQ-001 Parameter ADDR_W, default 12, byte-address width of the data memory (4096 bytes).
REQ-002 Parameter CNT_W, default 11, width of the word_count input.
REQ-003 Ports: clk  input  1  single clock; all logic rises on posedge clk.
REQ-004 Ports: reset  input  1  synchronous, active-low reset; sampled only on posedge clk.
REQ-005 Ports: start  input  1; base_addr  input  ADDR_W; word_count  input  CNT_W: dump request, sampled in IDLE only.
REQ-006 Ports: mem_rd_en  output  1; mem_addr  output  ADDR_W; mem_rdata  input  8: byte read port, data valid the cycle after mem_rd_en.
REQ-007 Ports: out_valid  output  1; out_ready  input  1; out_data  output  32; out_addr  output  ADDR_W; out_last  output  1: word stream.
REQ-008 Ports: busy  output  1 (high outside IDLE/DONE); done  output  1 (one-cycle pulse at completion).

Function
REQ-009 States SHALL be IDLE, READ, SEND, CSUM, DONE.
REQ-010 IDLE->READ when start=1; base_addr and word_count SHALL be latched in that cycle.
REQ-011 start with word_count=0 SHALL go IDLE->DONE, with no memory reads and no output words.
REQ-012 READ SHALL assert mem_rd_en for exactly 4 consecutive cycles, mem_addr = word base + 0,1,2,3.
REQ-013 Bytes SHALL be packed little-endian: byte at offset k into out_data[8k+7:8k].
REQ-014 out_valid SHALL first rise 6 cycles after the cycle where start=1 was sampled (reads in cycles 1-4, last data in cycle 5).
REQ-015 SEND: out_valid, out_data, out_addr and out_last SHALL hold stable until out_valid&&out_ready.
REQ-016 out_addr SHALL be the byte address of the word's byte 0.
REQ-017 After acceptance, the next word's first read SHALL issue the following cycle; word base advances by 4.
REQ-018 Addresses SHALL wrap modulo 2^ADDR_W (base 0xFFE reads 0xFFE,0xFFF,0x000,0x001).
REQ-019 out_last SHALL be high on the final stream word only; its acceptance leads to DONE (or CSUM, REQ-025).
REQ-020 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-021 start while busy SHALL be ignored; no re-latching of base_addr or word_count.

Reset
REQ-022 reset=0 at a clock edge SHALL force IDLE from any state, aborting any dump in progress.
REQ-023 Reset values: mem_rd_en=0, mem_addr=0, out_valid=0, out_data=0, out_addr=0, out_last=0, busy=0, done=0.
REQ-024 No word SHALL be emitted after reset deasserts until a new start.

Configuration
REQ-025 With MEM_DUMP_CHECKSUM_EN defined, after the last data word a CSUM word SHALL follow: 32-bit wrapping sum of all emitted data words, out_addr = base+4*word_count (mod 2^ADDR_W), out_last on it only.
REQ-026 Without MEM_DUMP_CHECKSUM_EN, the CSUM state and adder SHALL be absent and the last data word carries out_last.
REQ-027 With word_count=0 and checksum enabled, no CSUM word SHALL be emitted.

Structure
REQ-028 Package mem_dump_pkg SHALL hold the state enum, BYTES_PER_WORD=4, and default ADDR_W/CNT_W constants.
REQ-029 Sub-module mem_byte_packer SHALL hold the 4-byte little-endian shift/pack register; FSM and counters stay in mem_dump_reader.

Verification
REQ-030 Memory 0x000..0x007 = 01,02,...,08; start base=0, count=2, out_ready=1 -> words 0x04030201 @0x000, 0x08070605 @0x004 (last), done pulse.
REQ-031 Same stimulus, out_ready low 10 cycles on word 0 -> out_data/out_addr stable all 10 cycles, no extra mem reads.
REQ-032 base=0xFFE, count=1, bytes AA,BB@0xFFE/F, CC,DD@0x000/1 -> out_data 0xDDCCBBAA, out_addr 0xFFE.
REQ-033 count=0 -> done pulse, mem_rd_en and out_valid never asserted.
REQ-034 reset=0 in SEND of word 1 of 3 -> next cycle all outputs 0, state IDLE; second start mid-dump ignored.
REQ-035 MEM_DUMP_CHECKSUM_EN defined, REQ-030 data -> third word 0x0C0A0806 @0x008 with out_last.
